// File: rtl/uart_bus_responder.sv
// uart_bus_responder
//   CPU-bus responder for the UART window: DATA (addr 0) and STATUS/CTRL (addr 1)
//   byte registers, an 8N1 transmitter and receiver with a one-byte holding
//   register per direction, and a registered level interrupt.
// Ports
//   clk       system clock, all state on the rising edge
//   rst_n     synchronous active-low reset
//   cs        window chip select from the address decoder
//   addr      register select (CPU A0)
//   rwb       1 = read, 0 = write
//   stb       one-clock access strobe; an access commits on cs & stb
//   data_in   CPU write data
//   data_out  read data, 8'h00 while cs is low
//   txd       serial output, idle high
//   rxd       asynchronous serial input
//   irq       active-high level interrupt
module uart_bus_responder #(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115_200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs,
    input  logic       addr,
    input  logic       rwb,
    input  logic       stb,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       txd,
    input  logic       rxd,
    output logic       irq
);

    localparam int DIV = CLK_HZ / BAUD;
    localparam int TW  = $clog2(DIV);
    localparam logic [TW-1:0] BIT_LAST  = TW'(DIV - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(DIV / 2 - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

    // bus decode
    logic acc, rd0, wr0, wr1;
    assign acc = cs & stb;
    assign rd0 = acc &  rwb & ~addr;
    assign wr0 = acc & ~rwb & ~addr;
    assign wr1 = acc & ~rwb &  addr;

    // transmitter
    state_e          tx_state_q;
    logic [TW-1:0]   tx_cnt_q;
    logic [2:0]      tx_idx_q;
    logic [7:0]      tx_sh_q;
    logic            txd_q;
    logic            tx_busy;

    assign tx_busy = (tx_state_q != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_sh_q    <= '0;
            txd_q      <= 1'b1;
        end else begin
            case (tx_state_q)
                S_IDLE: begin
                    // writes while busy never reach here, so they are dropped
                    if (wr0) begin
                        tx_sh_q    <= data_in;
                        tx_cnt_q   <= '0;
                        txd_q      <= 1'b0;
                        tx_state_q <= S_START;
                    end
                end
                S_START: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q   <= '0;
                        tx_idx_q   <= '0;
                        txd_q      <= tx_sh_q[0];
                        tx_state_q <= S_DATA;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q <= '0;
                        if (tx_idx_q == 3'd7) begin
                            txd_q      <= 1'b1;
                            tx_state_q <= S_STOP;
                        end else begin
                            // bit 0 of the shifter always holds the bit on the line
                            tx_idx_q <= tx_idx_q + 3'd1;
                            txd_q    <= tx_sh_q[1];
                            tx_sh_q  <= tx_sh_q >> 1;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q   <= '0;
                        tx_state_q <= S_IDLE;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                default: tx_state_q <= S_IDLE;
            endcase
        end
    end

    // receiver, holding register, flags and control
    logic          rx_s1_q, rx_s2_q, rx_prev_q;
    state_e        rx_state_q;
    logic [TW-1:0] rx_cnt_q;
    logic [2:0]    rx_idx_q;
    logic [7:0]    rx_sh_q;
    logic [7:0]    rx_data_q;
    logic          rx_valid_q, rx_ovr_q, frame_err_q;
    logic          rx_ie_q, tx_ie_q;
    logic          irq_q, irq_d;

    assign irq_d = (rx_ie_q & rx_valid_q) | (tx_ie_q & ~tx_busy);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            rx_prev_q   <= 1'b1;
            rx_state_q  <= S_IDLE;
            rx_cnt_q    <= '0;
            rx_idx_q    <= '0;
            rx_sh_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            rx_ovr_q    <= 1'b0;
            frame_err_q <= 1'b0;
            rx_ie_q     <= 1'b0;
            tx_ie_q     <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            rx_s1_q   <= rxd;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            irq_q     <= irq_d;

            if (rd0) rx_valid_q <= 1'b0;
            if (wr1) begin
                rx_ie_q <= data_in[0];
                tx_ie_q <= data_in[1];
                if (data_in[2]) begin
                    rx_ovr_q    <= 1'b0;
                    frame_err_q <= 1'b0;
                end
            end

            // frame events are assigned after bus side effects so they take priority
            case (rx_state_q)
                S_IDLE: begin
                    if (rx_prev_q && !rx_s2_q) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= S_START;
                    end
                end
                S_START: begin
                    if (rx_cnt_q == HALF_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_idx_q   <= '0;
                        rx_state_q <= rx_s2_q ? S_IDLE : S_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q <= '0;
                        rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
                        if (rx_idx_q == 3'd7) rx_state_q <= S_STOP;
                        else                  rx_idx_q   <= rx_idx_q + 3'd1;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= S_IDLE;
                        if (rx_s2_q) begin
                            rx_data_q  <= rx_sh_q;
                            rx_valid_q <= 1'b1;
                            // a same-clock data read consumes the old byte: no overrun
                            if (rx_valid_q && !rd0) rx_ovr_q <= 1'b1;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                default: rx_state_q <= S_IDLE;
            endcase
        end
    end

    logic [7:0] status;
    assign status = {irq_q, 3'b000, frame_err_q, rx_ovr_q, tx_busy, rx_valid_q};

    always_comb begin
        data_out = '0;
        if (cs) data_out = addr ? status : rx_data_q;
    end

    assign txd = txd_q;
    assign irq = irq_q;

endmodule
